// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage buffer with valid/ready handshake.
// SKID=1 keeps a second entry so in_ready comes straight from a flop and
// never depends on out_ready; SKID=0 is a single entry whose in_ready looks
// at out_ready combinationally. flush empties the stage, and a saturating
// counter tracks the cycles spent stalled on downstream backpressure.
module pipe_stage_reg #(
  parameter int                WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}},
  parameter int                SKID        = 1,
  parameter int                STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   stall_clr
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m_q, s_q;
  logic             in_fire, out_fire;
  logic             load_m_in, load_m_skid, load_s;

  assign out_valid = (state != EMPTY);
  assign out_data  = m_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: only the FULL state blocks input.
      assign in_ready = (state != FULL) && !rst;
    end else begin : g_noskid
      // Single entry: accept when empty or when the held beat leaves now.
      assign in_ready = (!out_valid || out_ready) && !rst;
    end
  endgenerate

  // Next-state and register load selection; flush overrides any handshake.
  always_comb begin
    state_nxt   = state;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            load_m_in = 1'b1;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_m_in = 1'b1;
          end else if (in_fire && (SKID != 0)) begin
            load_s    = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            load_m_skid = 1'b1;
            state_nxt   = BUSY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Payload registers; on flush they simply hold (contents are dead).
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= RESET_VALUE;
      s_q <= RESET_VALUE;
    end else begin
      if (load_m_in)        m_q <= in_data;
      else if (load_m_skid) m_q <= s_q;
      if (load_s)           s_q <= in_data;
    end
  end

  // Saturating stall counter; clear wins over increment, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst || stall_clr)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != STALL_MAX))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: a SKID=1 instance (4-bit stall counter) and a
// SKID=0 instance (16-bit stall counter) share one stimulus stream. Each has
// its own queue-based reference model; an intake process pushes accepted
// beats and a monitor pops and compares whenever a beat leaves the DUT.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, stall_clr;
  logic [31:0] in_data;
  logic [1:0]  in_rdy;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int SK = (gi == 0) ? 1 : 0;
    localparam int CW = (gi == 0) ? 4 : 16;

    logic          in_ready, out_valid;
    logic [31:0]   out_data;
    logic [CW-1:0] stall_cnt;

    pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(32'h0), .SKID(SK), .STALL_CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );
    assign in_rdy[gi] = in_ready;

    // Reference model: FIFO of held beats (depth 2 with skid, 1 without).
    logic [31:0] sb[$];
    int unsigned stall_m = 0;
    int unsigned stall_max = (1 << CW) - 1;
    logic        er, ev, fire_in, rst_q;

    initial begin
      fire_in = 1'b0;
      rst_q   = 1'b0;
    end

    // Monitor: compare visible outputs against the model, pop on out_fire.
    always @(negedge clk) begin
      ev = (sb.size() != 0);
      if (rst)          er = 1'b0;
      else if (SK != 0) er = (sb.size() < 2);
      else              er = (sb.size() == 0) || out_ready;
      chk($sformatf("i%0d.in_ready", gi), 32'(in_ready), 32'(er));
      chk($sformatf("i%0d.out_valid", gi), 32'(out_valid), 32'(ev));
      chk($sformatf("i%0d.stall_cnt", gi), 32'(stall_cnt), stall_m);
      if (ev)         chk($sformatf("i%0d.out_data", gi), out_data, sb[0]);
      else if (rst_q) chk($sformatf("i%0d.reset_data", gi), out_data, 32'h0);
      fire_in = in_valid && er && !flush;
      if (rst || stall_clr)                           stall_m = 0;
      else if (ev && !out_ready && stall_m < stall_max) stall_m = stall_m + 1;
      if (ev && out_ready) void'(sb.pop_front());
    end

    // Intake: record accepted beats at the clock edge; rst/flush drop all.
    always @(posedge clk) begin
      rst_q = rst;
      if (rst || flush) sb.delete();
      else if (fire_in) sb.push_back(in_data);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a beat and hold it until the skid instance accepts it.
  task automatic send(input logic [31:0] d);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = in_rdy[0];
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total++;
      $display("FAIL send_timeout: beat %0h not accepted within 50 cycles", d);
    end
  endtask

  initial begin
    // Reset held two cycles with a beat presented; nothing may be captured.
    rst = 1'b1; flush = 1'b0; stall_clr = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    idle(2);
    rst = 1'b0; in_valid = 1'b0;
    idle(1);

    // Back-to-back streaming.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(32'(i));
    in_valid = 1'b0;
    idle(3);

    // Backpressure: A into M, B into S, C held upstream.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; idle(1);
    in_data = 32'hB; idle(1);
    in_data = 32'hC; idle(3);
    out_ready = 1'b1;
    send(32'hC);
    in_valid = 1'b0;
    idle(4);

    // Flush while full, with a beat offered in the same cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; idle(1);
    in_data = 32'h22; idle(1);
    flush = 1'b1; in_data = 32'h33; idle(1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(3);

    // Held beat, then out_ready rises together with a new beat.
    out_ready = 1'b0;
    send(32'h55);
    in_valid = 1'b1; in_data = 32'h66; idle(1);
    out_ready = 1'b1; in_data = 32'h77; idle(1);
    in_valid = 1'b0;
    idle(4);

    // Long stall to saturate the 4-bit counter, then clear mid-stall.
    out_ready = 1'b0;
    send(32'h99);
    in_valid = 1'b0;
    idle(20);
    stall_clr = 1'b1; idle(1);
    stall_clr = 1'b0; idle(3);
    out_ready = 1'b1;
    idle(3);

    // Random traffic with occasional reset, flush and counter clear.
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      stall_clr = ($urandom_range(0, 19) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      idle(1);
    end
    rst = 1'b0; flush = 1'b0; stall_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, optional skid buffer, flush and stall counter. It generalises the team's fixed 32-bit enabled register into a reusable inter-stage buffer for the 5-stage CPU (IF/ID, ID/EX, EX/MEM, MEM/WB). It sustains full throughput under backpressure without a combinational ready path, and it supports branch-mispredict flush.

## Interface
- WIDTH, 32, payload width in bits (>=1)
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into data registers on reset
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single entry, combinational in_ready
- STALL_CNT_W, 16, width of saturating stall counter
- clk  input  1  clock, all state on posedge
- rst  input  1  reset, synchronous, active-high; clock clk
- flush  input  1  synchronous discard of all held entries
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  stage holds a beat for downstream
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  payload of oldest held beat
- stall_cnt  output  STALL_CNT_W  cycles with out_valid && !out_ready, saturating
- stall_clr  input  1  synchronous clear of stall_cnt

## Operation
- Storage: main register M (drives out_data) and skid register S (SKID=1 only).
- States: EMPTY (nothing held), BUSY (M valid), FULL (M and S valid; SKID=1 only).
- in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- out_valid = (state != EMPTY). out_data = M.
- SKID=1: in_ready = (state != FULL) && !rst. It depends only on state, never on out_ready.
- SKID=0: in_ready = (!out_valid || out_ready) && !rst. FULL is unreachable.
- EMPTY: in_fire -> M<=in_data, BUSY.
- BUSY: in_fire && out_fire -> M<=in_data, stay BUSY.
- BUSY: in_fire only -> S<=in_data, FULL (SKID=1). With SKID=0 this case is impossible.
- BUSY: out_fire only -> EMPTY.
- FULL: out_fire -> M<=S, BUSY. No input is accepted in FULL.
- Priority: rst > flush > handshake transitions.
- flush: state<=EMPTY next edge.
  - Any beat presented that cycle is discarded even if in_ready=1.
  - M and S contents hold and are don't-care.
  - Downstream must not treat a same-cycle out_fire as a consumed beat in any special way; the handshake completes normally.
- stall_cnt:
  - Increments by 1 when out_valid && !out_ready.
  - Saturates at 2^STALL_CNT_W-1.
  - stall_clr zeroes it with priority over increment.
  - flush does not clear it.
- Data ordering: strict FIFO. No beat is duplicated or dropped except by flush or rst.

## Timing
- Reset values: state EMPTY, M=S=RESET_VALUE, out_valid=0, out_data=RESET_VALUE, stall_cnt=0, in_ready=0 while rst high.
- After rst deasserts: in_ready=1 in the same cycle (state is EMPTY).
- Latency: a beat accepted at edge N appears on out_valid/out_data in cycle N+1 (one register stage).
- Throughput: 1 beat/cycle when out_ready stays high.
- SKID=1: in_ready falls one cycle after the first unanswered backpressure cycle. This is exactly the beat absorbed by S.
- FULL -> BUSY at out_fire; in_ready returns high the following cycle.
- rst mid-operation: all held beats are lost and the state goes to EMPTY at that edge, regardless of in/out handshakes.
- flush and in_valid in the same cycle: the beat is dropped and out_valid=0 next cycle.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, in_data=0xDEADBEEF. Required: in_ready=0, out_valid=0, out_data=0, stall_cnt=0 throughout; nothing is captured.
- Streaming: out_ready=1, send 0x1..0x8 back-to-back. Required: out_data=0x1..0x8 on consecutive cycles with 1-cycle latency; in_ready stays 1; stall_cnt=0.
- Backpressure (SKID=1): send 0xA, 0xB, 0xC with out_ready=0.
  - Required: 0xA in M, 0xB in S, in_ready=0 on the 3rd cycle, 0xC is held upstream.
  - Then raise out_ready: output order 0xA, 0xB, 0xC, and stall_cnt equals the number of cycles out_ready was low while out_valid was high.
- Flush: in FULL with 0x11/0x22 held, pulse flush together with in_valid (0x33). Required: out_valid=0 next cycle, in_ready=1, no 0x11/0x22/0x33 ever emitted.
- SKID=0 variant: out_ready=0 with one beat held. Required: in_ready=0 combinationally; toggling out_ready=1 gives in_ready=1 in the same cycle and a simultaneous replace of M.
- Stall counter saturation (STALL_CNT_W=4): 20 stall cycles. Required: stall_cnt sticks at 15; stall_clr then yields 0 next cycle even though stalling continues.
